// File: rtl/box2x_down_if.sv
// Pixel-stream bundle for the 2:1 box downscaler.
// Source side drives ce_in/inputpixel/reset_line/reset_frame; sink returns out_*.
interface box2x_down_if #(
    parameter int PW = 24,
    parameter int XW = 10
);
    logic          ce_in;
    logic [PW-1:0] inputpixel;
    logic          reset_line;
    logic          reset_frame;
    logic          out_valid;
    logic [PW-1:0] out_pixel;
    logic [XW-1:0] out_x;
    logic          out_first;

    modport master (
        output ce_in, inputpixel, reset_line, reset_frame,
        input  out_valid, out_pixel, out_x, out_first
    );

    modport slave (
        input  ce_in, inputpixel, reset_line, reset_frame,
        output out_valid, out_pixel, out_x, out_first
    );
endinterface

// File: rtl/box2x_down.sv
// 2:1 box-filter downscaler: averages each 2x2 pixel block into one output pixel.
// Ports: clk, reset_n (async, active low); bus.slave carries the ce_in-qualified
// pixel stream in and the out_valid strobe with out_pixel/out_x/out_first out.
module box2x_down #(
    parameter int LENGTH     = 768,
    parameter bit HALF_DEPTH = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    box2x_down_if.slave  bus
);
    localparam int C      = HALF_DEPTH ? 4 : 8;
    localparam int PW     = 3 * C;
    localparam int AWIDTH = $clog2(LENGTH) - 1;
    localparam int XW     = AWIDTH + 1;
    localparam int HW     = C + 1;
    localparam int BW     = 3 * HW;
    localparam int IW     = $clog2(2 * LENGTH + 1);

    localparam logic [IW-1:0] X_END = IW'(2 * LENGTH);

    logic [IW-1:0] in_x_q, in_x_d;
    logic          odd_line_q, odd_line_d;
    logic          old_rl_q, old_rl_d;
    logic          old_rf_q, old_rf_d;
    logic [PW-1:0] pair_q, pair_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_pixel_q, out_pixel_d;
    logic [XW-1:0] out_x_q, out_x_d;
    logic          out_first_q, out_first_d;

    logic [BW-1:0] mem [LENGTH];
    logic [BW-1:0] rd_q;

    logic          line_start;
    logic          frame_start;
    logic [IW-1:0] x_eff;
    logic          accept;
    logic          is_odd;
    logic [XW-1:0] col;
    logic          wr_en;
    logic          rd_en;
    logic [BW-1:0] hsum;
    logic [PW-1:0] avg;
    logic [C+1:0]  tot [3];

    // Per-channel horizontal pair sum and rounded 2x2 average.
    // Worst case 4*max+2 still fits C+2 bits, so avg cannot overflow.
    always_comb begin
        hsum = '0;
        avg  = '0;
        for (int c = 0; c < 3; c++) begin
            tot[c] = '0;
            hsum[c*HW +: HW] = {1'b0, pair_q[c*C +: C]}
                             + {1'b0, bus.inputpixel[c*C +: C]};
            tot[c] = {1'b0, hsum[c*HW +: HW]}
                   + {1'b0, rd_q[c*HW +: HW]}
                   + (C+2)'(2);
            avg[c*C +: C] = C'(tot[c] >> 2);
        end
    end

    always_comb begin
        line_start  = bus.ce_in & old_rl_q & ~bus.reset_line;
        frame_start = line_start & old_rf_q & ~bus.reset_frame;
        // The pixel that ends hblank is column 0 of the new line.
        x_eff       = line_start ? '0 : in_x_q;
        accept      = bus.ce_in & ~bus.reset_line & (x_eff != X_END);
        is_odd      = x_eff[0];
        col         = XW'(x_eff >> 1);

        in_x_d      = in_x_q;
        odd_line_d  = odd_line_q;
        old_rl_d    = old_rl_q;
        old_rf_d    = old_rf_q;
        pair_d      = pair_q;
        out_valid_d = 1'b0;
        out_pixel_d = out_pixel_q;
        out_x_d     = out_x_q;
        out_first_d = 1'b0;

        if (bus.ce_in) begin
            old_rl_d = bus.reset_line;
            old_rf_d = bus.reset_frame;
        end

        if (line_start) begin
            in_x_d     = '0;
            odd_line_d = frame_start ? 1'b0 : ~odd_line_q;
        end

        if (accept) begin
            in_x_d = x_eff + 1'b1;
            if (!is_odd) begin
                pair_d = bus.inputpixel;
            end
        end

        // Line parity used this cycle must include a line start happening now.
        rd_en = accept & ~is_odd & odd_line_d;
        wr_en = accept & is_odd & ~odd_line_d;

        if (accept && is_odd && odd_line_d) begin
            out_valid_d = 1'b1;
            out_pixel_d = avg;
            out_x_d     = col;
            out_first_d = (col == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_x_q      <= '0;
            odd_line_q  <= 1'b0;
            old_rl_q    <= 1'b0;
            old_rf_q    <= 1'b0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_x_q     <= '0;
            out_first_q <= 1'b0;
        end else begin
            in_x_q      <= in_x_d;
            odd_line_q  <= odd_line_d;
            old_rl_q    <= old_rl_d;
            old_rf_q    <= old_rf_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_x_q     <= out_x_d;
            out_first_q <= out_first_d;
        end
    end

    // Line buffer of even-line pair sums; read issued on the even pixel is
    // ready by the matching odd pixel, even with ce_in high every clock.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[col] <= hsum;
        end
        if (rd_en) begin
            rd_q <= mem[col];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pixel = out_pixel_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_first = out_first_q;
endmodule

// File: tb/tb_box2x_down.sv
// Scoreboard bench for box2x_down (RGB888 and RGB444 instances, LENGTH=4).
// Expected blocks are queued as lines are driven and popped on each strobe.
module tb_box2x_down;
    localparam int L = 4;

    typedef struct packed {
        logic [23:0] px;
        logic [1:0]  x;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    box2x_down_if #(.PW(24), .XW(2)) b8();
    box2x_down_if #(.PW(12), .XW(2)) b4();

    box2x_down #(.LENGTH(L), .HALF_DEPTH(1'b0)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(b8.slave)
    );
    box2x_down #(.LENGTH(L), .HALF_DEPTH(1'b1)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(b4.slave)
    );

    exp_t q8[$];
    exp_t q4[$];
    int total = 0;
    int bad = 0;
    logic [23:0] lp [2*L+3];
    logic [23:0] prev [2*L];
    bit mo = 1'b0;

    function automatic logic [23:0] avg4(input logic [23:0] a, input logic [23:0] b,
                                         input logic [23:0] c, input logic [23:0] d);
        logic [23:0] r;
        int s;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = 2;
            s = s + a[8*ch +: 8];
            s = s + b[8*ch +: 8];
            s = s + c[8*ch +: 8];
            s = s + d[8*ch +: 8];
            r[8*ch +: 8] = 8'(s / 4);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (b8.out_valid === 1'b1) begin
            total++;
            if (q8.size() == 0) begin
                bad++;
                $display("FAIL strobe8 unexpected: x=%0d px=%h", b8.out_x, b8.out_pixel);
            end else begin
                e = q8.pop_front();
                if (b8.out_pixel !== e.px || b8.out_x !== e.x ||
                    b8.out_first !== (e.x == 2'd0)) begin
                    bad++;
                    $display("FAIL strobe8: got px=%h x=%0d first=%b want px=%h x=%0d first=%b",
                             b8.out_pixel, b8.out_x, b8.out_first, e.px, e.x, e.x == 2'd0);
                end
            end
        end
        if (b4.out_valid === 1'b1) begin
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL strobe4 unexpected: x=%0d px=%h", b4.out_x, b4.out_pixel);
            end else begin
                e = q4.pop_front();
                if (b4.out_pixel !== e.px[11:0] || b4.out_x !== e.x) begin
                    bad++;
                    $display("FAIL strobe4: got px=%h x=%0d want px=%h x=%0d",
                             b4.out_pixel, b4.out_x, e.px[11:0], e.x);
                end
            end
        end
    end

    task automatic send_line(input int n, input bit ff, input bit b2b);
        int lim;
        lim = (n < 2*L) ? n : 2*L;
        if (ff) mo = 1'b0;
        else mo = ~mo;
        if (!mo) begin
            for (int i = 0; i < lim; i++) prev[i] = lp[i];
        end else begin
            for (int j = 0; 2*j+1 < lim; j++) begin
                q8.push_back('{px: avg4(prev[2*j], prev[2*j+1], lp[2*j], lp[2*j+1]),
                               x: 2'(j)});
            end
        end
        repeat (3) begin
            @(negedge clk);
            b8.ce_in = 1'b1;
            b8.reset_line = 1'b1;
            b8.reset_frame = ff;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b8.ce_in = 1'b1;
            b8.reset_line = 1'b0;
            b8.reset_frame = 1'b0;
            b8.inputpixel = lp[i];
            if (!b2b) begin
                @(negedge clk);
                b8.ce_in = 1'b0;
            end
        end
        @(negedge clk);
        b8.ce_in = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q8.size() != 0 || q4.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_line(input int n);
        for (int i = 0; i < n; i++) lp[i] = 24'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #13;
        total++;
        if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", b8.out_valid); end
        total++;
        if (b8.out_pixel !== 24'h0) begin bad++; $display("FAIL rst_pixel: got %h want 0", b8.out_pixel); end
        total++;
        if (b8.out_x !== 2'd0) begin bad++; $display("FAIL rst_x: got %0d want 0", b8.out_x); end
        total++;
        if (b8.out_first !== 1'b0) begin bad++; $display("FAIL rst_first: got %b want 0", b8.out_first); end
        total++;
        if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid4: got %b want 0", b4.out_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        mo = 1'b0;
    endtask

    task automatic test_flat();
        for (int i = 0; i < 2*L; i++) lp[i] = 24'h102030;
        send_line(2*L, 1'b1, 1'b0);
        send_line(2*L, 1'b0, 1'b0);
        drain();
        total++;
        if (q8.size() != 0) begin bad++; $display("FAIL flat_drain: left %0d want 0", q8.size()); end
    endtask

    task automatic test_rounding();
        logic [23:0] ev [8] = '{24'h443300, 24'h443300, 24'h443301, 24'h443301,
                                24'hFFFFFF, 24'hFFFFFF, 24'h000007, 24'h000009};
        logic [23:0] od [8] = '{24'h443300, 24'h443302, 24'h443301, 24'h443300,
                                24'hFFFFFF, 24'hFFFFFF, 24'h010203, 24'h0A0B0C};
        for (int i = 0; i < 8; i++) lp[i] = ev[i];
        send_line(8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) lp[i] = od[i];
        send_line(8, 1'b0, 1'b0);
        drain();
        total++;
        if (q8.size() != 0) begin bad++; $display("FAIL round_drain: left %0d want 0", q8.size()); end
    endtask

    task automatic test_back_to_back();
        rand_line(2*L);
        send_line(2*L, 1'b1, 1'b1);
        rand_line(2*L);
        send_line(2*L, 1'b0, 1'b1);
        drain();
        total++;
        if (q8.size() != 0) begin bad++; $display("FAIL b2b_drain: left %0d want 0", q8.size()); end
    endtask

    task automatic test_frame_and_length();
        rand_line(2*L);
        send_line(2*L, 1'b1, 1'b0);
        rand_line(2*L+3);
        send_line(2*L+3, 1'b1, 1'b1);
        rand_line(2*L);
        send_line(2*L, 1'b0, 1'b1);
        rand_line(2*L);
        send_line(2*L, 1'b1, 1'b0);
        rand_line(7);
        send_line(7, 1'b0, 1'b0);
        drain();
        total++;
        if (q8.size() != 0) begin bad++; $display("FAIL frame_drain: left %0d want 0", q8.size()); end
    endtask

    task automatic test_reset_mid_line();
        rand_line(2*L);
        send_line(2*L, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            b8.ce_in = 1'b1;
            b8.reset_line = 1'b1;
            b8.reset_frame = 1'b0;
        end
        @(negedge clk);
        b8.reset_line = 1'b0;
        b8.inputpixel = 24'h0F0F0F;
        @(negedge clk);
        b8.inputpixel = 24'hF0F0F0;
        @(posedge clk);
        #2;
        total++;
        if (b8.out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre: valid=%b want 1", b8.out_valid); end
        reset_n = 1'b0;
        #1;
        total++;
        if (b8.out_valid !== 1'b0 || b8.out_x !== 2'd0 || b8.out_pixel !== 24'h0) begin
            bad++;
            $display("FAIL midrst_clear: valid=%b x=%0d px=%h want 0 0 0",
                     b8.out_valid, b8.out_x, b8.out_pixel);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b8.ce_in = 1'b1;
            b8.inputpixel = 24'($urandom);
        end
        @(negedge clk);
        b8.ce_in = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (q8.size() != 0) begin bad++; $display("FAIL midrst_quiet: left %0d want 0", q8.size()); end
        mo = 1'b0;
        rand_line(2*L);
        send_line(2*L, 1'b1, 1'b1);
        rand_line(2*L);
        send_line(2*L, 1'b0, 1'b1);
        drain();
        total++;
        if (q8.size() != 0) begin bad++; $display("FAIL midrst_resume: left %0d want 0", q8.size()); end
    endtask

    task automatic drive4_line(input logic [11:0] a, input logic [11:0] b, input bit ff);
        repeat (3) begin
            @(negedge clk);
            b4.ce_in = 1'b1;
            b4.reset_line = 1'b1;
            b4.reset_frame = ff;
        end
        @(negedge clk);
        b4.reset_line = 1'b0;
        b4.reset_frame = 1'b0;
        b4.inputpixel = a;
        @(negedge clk);
        b4.inputpixel = b;
        @(negedge clk);
        b4.ce_in = 1'b0;
    endtask

    task automatic test_half_depth();
        q4.push_back('{px: 24'h000800, x: 2'd0});
        drive4_line(12'hF00, 12'h000, 1'b1);
        drive4_line(12'hF00, 12'h000, 1'b0);
        drain();
        total++;
        if (q4.size() != 0) begin bad++; $display("FAIL half_drain: left %0d want 0", q4.size()); end
    endtask

    initial begin
        b8.ce_in = 1'b0;
        b8.inputpixel = '0;
        b8.reset_line = 1'b1;
        b8.reset_frame = 1'b1;
        b4.ce_in = 1'b0;
        b4.inputpixel = '0;
        b4.reset_line = 1'b1;
        b4.reset_frame = 1'b1;
        test_reset();
        test_flat();
        test_rounding();
        test_back_to_back();
        test_frame_and_length();
        test_reset_mid_line();
        test_half_depth();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
